// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: line levels, framer state encoding, frame width.
// Defining SERIAL_TX_FRAMER_PARITY_EN adds one parity bit to every frame.
package serial_pkg;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        GUARD = ST_GUARD,
        BUSY  = ST_BUSY
    } framer_state_e;

`ifdef SERIAL_TX_FRAMER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int fw(input int data_width, input int parity, input int stop_bits);
        return 1 + data_width + parity + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full, pop is ignored when empty.
module sync_fifo #(
    parameter int p_WIDTH = 8,
    parameter int p_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [p_WIDTH-1:0]             iv_wdata,
    input  logic                           i_push,
    output logic                           o_ready,
    input  logic                           i_pop,
    output logic [p_WIDTH-1:0]             ov_rdata,
    output logic [$clog2(p_DEPTH+1)-1:0]   ov_level
);

    localparam int AW = $clog2(p_DEPTH);
    localparam int LW = $clog2(p_DEPTH+1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(p_DEPTH);

    logic [p_WIDTH-1:0] mem_q [p_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic               do_push;
    logic               do_pop;

    assign o_ready  = (level_q != FULL_LEVEL);
    assign do_push  = i_push && o_ready;
    assign do_pop   = i_pop && (level_q != '0);
    assign ov_rdata = mem_q[rd_ptr_q];
    assign ov_level = level_q;

    // Pointers are exactly log2(depth) wide so they wrap without compare logic.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= iv_wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_framer.sv
// Buffers core bytes and hands UART-style frames (start, data LSB first, parity, stop) to the serializer.
// SERIAL_TX_FRAMER_PARITY_EN enables the parity bit; SERIAL_TX_FRAMER_PARITY_ODD makes it odd.
module serial_tx_framer
    import serial_pkg::*;
#(
    parameter int p_DATA_WIDTH = 8,
    parameter int p_DEPTH      = 4,
    parameter int p_STOP_BITS  = 1
) (
    input  logic                                                i_clk,
    input  logic                                                i_reset,
    input  logic [p_DATA_WIDTH-1:0]                             iv_data,
    input  logic                                                i_valid,
    output logic                                                o_ready,
    output logic [fw(p_DATA_WIDTH, PAR_BITS, p_STOP_BITS)-1:0]  ov_frame,
    output logic                                                o_frame_ready,
    input  logic                                                i_tx_empty,
    output logic [$clog2(p_DEPTH+1)-1:0]                        ov_level,
    output logic                                                o_idle
);

    localparam int FW = fw(p_DATA_WIDTH, PAR_BITS, p_STOP_BITS);
    localparam int LW = $clog2(p_DEPTH+1);

    framer_state_e          state_q, state_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic                   frame_ready_q, frame_ready_d;
    logic [FW-1:0]          packed_frame;
    logic                   pop;
    logic [p_DATA_WIDTH-1:0] head;
    logic [LW-1:0]          level;

    sync_fifo #(
        .p_WIDTH (p_DATA_WIDTH),
        .p_DEPTH (p_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .iv_wdata (iv_data),
        .i_push   (i_valid),
        .o_ready  (o_ready),
        .i_pop    (pop),
        .ov_rdata (head),
        .ov_level (level)
    );

    // Stop bits fill everything above the data/parity field.
    always_comb begin
        packed_frame                 = {FW{STOP_LEVEL}};
        packed_frame[0]              = START_LEVEL;
        packed_frame[p_DATA_WIDTH:1] = head;
`ifdef SERIAL_TX_FRAMER_PARITY_EN
`ifdef SERIAL_TX_FRAMER_PARITY_ODD
        packed_frame[p_DATA_WIDTH+1] = ~^head;
`else
        packed_frame[p_DATA_WIDTH+1] = ^head;
`endif
`endif
    end

    // GUARD skips one look at i_tx_empty so a slow-to-fall flag cannot trigger a second load.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        frame_ready_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            IDLE: begin
                if ((level != '0) && i_tx_empty) begin
                    pop           = 1'b1;
                    frame_d       = packed_frame;
                    frame_ready_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE:   state_d = GUARD;
            GUARD:   state_d = BUSY;
            BUSY:    if (i_tx_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            frame_q       <= '1;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    assign ov_frame      = frame_q;
    assign o_frame_ready = frame_ready_q;
    assign ov_level      = level;
    assign o_idle        = (level == '0) && (state_q == IDLE) && i_tx_empty;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Scoreboard bench for serial_tx_framer: frames are queued at push time and a monitor
// pairs each load strobe with the oldest queued frame; a serializer model drives i_tx_empty.
`timescale 1ns/1ps
module tb_serial_tx_framer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int STOP  = 1;
`ifdef SERIAL_TX_FRAMER_PARITY_EN
    localparam int TB_PAR = 1;
`ifdef SERIAL_TX_FRAMER_PARITY_ODD
    localparam logic [31:0] A5_FRAME = 32'h74A;
`else
    localparam logic [31:0] A5_FRAME = 32'h54A;
`endif
`else
    localparam int TB_PAR = 0;
    localparam logic [31:0] A5_FRAME = 32'h34A;
`endif
    localparam int FW = 1 + DW + TB_PAR + STOP;
    localparam int LW = $clog2(DEPTH+1);

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [DW-1:0] iv_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [FW-1:0] ov_frame;
    logic          o_frame_ready;
    logic          i_tx_empty;
    logic [LW-1:0] ov_level;
    logic          o_idle;

    logic holdEmptyLow = 1'b0;
    int   busyCnt = 0;
    assign i_tx_empty = !holdEmptyLow && (busyCnt == 0);

    typedef struct {
        logic [FW-1:0] frame;
        int            pushCycle;
        bit            checkLat;
    } exp_t;

    exp_t expQ[$];
    int   cycle = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   strobeCount = 0;
    bit   latencyCheck = 1'b0;
    bit   prevStrobe = 1'b0;
    logic prevEmpty = 1'b1;

    serial_tx_framer #(
        .p_DATA_WIDTH (DW),
        .p_DEPTH      (DEPTH),
        .p_STOP_BITS  (STOP)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .iv_data       (iv_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .ov_frame      (ov_frame),
        .o_frame_ready (o_frame_ready),
        .i_tx_empty    (i_tx_empty),
        .ov_level      (ov_level),
        .o_idle        (o_idle)
    );

    initial forever #5 i_clk = ~i_clk;
    initial forever begin
        @(posedge i_clk);
        cycle++;
    end

    function automatic logic [FW-1:0] modelFrame(input logic [DW-1:0] b);
        logic [FW-1:0] f;
        f       = '1;
        f[0]    = 1'b0;
        f[DW:1] = b;
`ifdef SERIAL_TX_FRAMER_PARITY_EN
`ifdef SERIAL_TX_FRAMER_PARITY_ODD
        f[DW+1] = ~^b;
`else
        f[DW+1] = ^b;
`endif
`endif
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Serializer: loads on the edge that closes a strobe cycle, then reports busy for 10 cycles.
    initial begin
        bit loadSeen;
        forever begin
            @(negedge i_clk);
            loadSeen = o_frame_ready && !i_reset;
            @(posedge i_clk);
            #1;
            if (loadSeen) busyCnt = 10;
            else if (busyCnt > 0) busyCnt--;
        end
    end

    // Monitor: records accepted pushes and checks every strobe against the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                if (i_valid && o_ready) begin
                    e.frame     = modelFrame(iv_data);
                    e.pushCycle = cycle;
                    e.checkLat  = latencyCheck;
                    expQ.push_back(e);
                end
                if (o_frame_ready) begin
                    strobeCount++;
                    checkOutput("strobe not adjacent", 32'(prevStrobe), 32'd0);
                    checkOutput("tx_empty high before strobe", 32'(prevEmpty), 32'd1);
                    checkOutput("frame pending for strobe", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("frame order/content", 32'(ov_frame), 32'(e.frame));
                        if (e.checkLat) checkOutput("strobe latency", 32'(cycle - e.pushCycle), 32'd2);
                    end
                end
            end
            prevStrobe = o_frame_ready;
            prevEmpty  = i_tx_empty;
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] b);
        int waited;
        waited  = 0;
        iv_data = b;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && waited < 50) begin
            waited++;
            @(negedge i_clk);
        end
        if (!o_ready) checkOutput("push accepted in time", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (!(o_idle && expQ.size() == 0) && n < 500) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(o_idle && expQ.size() == 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            s0;
        logic [DW-1:0] fillBytes [4];
        fillBytes = '{8'h11, 8'h22, 8'h33, 8'h44};

        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset o_ready", 32'(o_ready), 32'd1);
        checkOutput("reset ov_level", 32'(ov_level), 32'd0);
        checkOutput("reset o_frame_ready", 32'(o_frame_ready), 32'd0);
        checkOutput("reset o_idle", 32'(o_idle), 32'd1);
        checkOutput("reset ov_frame", 32'(ov_frame), 32'((1 << FW) - 1));
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        latencyCheck = 1'b1;
        applyStimulus(8'hA5);
        latencyCheck = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("A5 strobe", 32'(o_frame_ready), 32'd1);
        checkOutput("A5 frame", 32'(ov_frame), A5_FRAME);
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("A5 frame held", 32'(ov_frame), A5_FRAME);
        checkOutput("A5 strobe single", 32'(o_frame_ready), 32'd0);
        waitDrain("single byte drain");

        holdEmptyLow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fillBytes[i]);
            checkOutput("fill o_ready", 32'(o_ready), 32'(i < 3));
        end
        checkOutput("fill ov_level", 32'(ov_level), 32'd4);
        iv_data = 8'h55;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checkOutput("stalled push o_ready", 32'(o_ready), 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        checkOutput("stalled ov_level", 32'(ov_level), 32'd4);
        holdEmptyLow = 1'b0;
        waitDrain("fill drain");

        s0 = strobeCount;
        applyStimulus(8'h01);
        applyStimulus(8'h80);
        applyStimulus(8'hFE);
        waitDrain("back-to-back drain");
        checkOutput("back-to-back strobe count", 32'(strobeCount - s0), 32'd3);

        holdEmptyLow = 1'b1;
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        checkOutput("pre-simultaneous ov_level", 32'(ov_level), 32'd2);
        holdEmptyLow = 1'b0;
        applyStimulus(8'h0F);
        checkOutput("simultaneous ov_level", 32'(ov_level), 32'd2);
        checkOutput("simultaneous strobe", 32'(o_frame_ready), 32'd1);
        checkOutput("simultaneous oldest", 32'(ov_frame), 32'(modelFrame(8'h5A)));

        applyStimulus(8'h3C);
        checkOutput("busy ov_level", 32'(ov_level), 32'd3);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        expQ.delete();
        @(posedge i_clk);
        #1;
        checkOutput("midframe reset ov_level", 32'(ov_level), 32'd0);
        checkOutput("midframe reset o_ready", 32'(o_ready), 32'd1);
        checkOutput("midframe reset o_frame_ready", 32'(o_frame_ready), 32'd0);
        checkOutput("midframe reset ov_frame", 32'(ov_frame), 32'((1 << FW) - 1));
        i_reset = 1'b0;
        s0 = strobeCount;
        repeat (40) @(posedge i_clk);
        #1;
        checkOutput("no strobe after reset", 32'(strobeCount - s0), 32'd0);
        checkOutput("idle after reset", 32'(o_idle), 32'd1);
        checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
